// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, word type, round constants and
// the byte-rotation helper used by the key schedule.
package aes_pkg;

    // Number of rounds for a 128-bit key.
    localparam logic [3:0] AES_NR = 4'd10;

    // One 32-bit key-schedule word, byte 0 in bits [31:24].
    typedef logic [31:0] aes_word_t;

    // Round constants, indexed by the round being produced (1..10).
    localparam logic [7:0] AES_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Rotate a word left by one byte: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Round constant lookup; indices outside 1..10 yield zero so the
    // schedule never reads past the table when it is saturated.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (idx == i[3:0]) begin
                r = AES_RCON[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: pure combinational 8-bit substitution.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Table lookup.
    assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand_128.sv
// Sequential AES-128 key schedule: one round key per advance.
//
// Control semantics: kld and adv are single-cycle request strobes with no
// back-pressure; they are always accepted on the rising edge where they are
// high (kld takes priority over adv). key_valid is the qualifier for
// w_0..w_3: the words are meaningful exactly while key_valid is 1, and
// round_cnt names which round key they are.
module aes_key_expand_128
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         kld,
    input  logic [127:0] key,
    input  logic         adv,
    output logic [31:0]  w_0,
    output logic [31:0]  w_1,
    output logic [31:0]  w_2,
    output logic [31:0]  w_3,
    output logic [3:0]   round_cnt,
    output logic         key_valid,
    output logic         key_last
);

    aes_word_t  rot_w3;
    aes_word_t  sub_w3;
    aes_word_t  t_word;
    aes_word_t  w0_n;
    aes_word_t  w1_n;
    aes_word_t  w2_n;
    aes_word_t  w3_n;
    logic [3:0] round_n;
    logic       do_adv;

    assign rot_w3 = rot_word(w_3);

    // SubWord: four byte-wide S-box lookups on the rotated last word.
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (rot_w3[8*i +: 8]),
            .dout (sub_w3[8*i +: 8])
        );
    end

    // An advance only counts when a key is loaded, the schedule is not
    // finished, and no load is competing in the same cycle.
    assign do_adv  = adv & ~kld & key_valid & (round_cnt < AES_NR);
    assign round_n = round_cnt + 4'd1;

    // Next round key: substituted word mixed with rcon, then the XOR chain.
    always_comb begin
        t_word = sub_w3 ^ {rcon_lookup(round_n), 24'h000000};
        w0_n   = w_0 ^ t_word;
        w1_n   = w_1 ^ w0_n;
        w2_n   = w_2 ^ w1_n;
        w3_n   = w_3 ^ w2_n;
    end

    // Schedule registers: load restarts at round 0, advance steps one round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_0       <= '0;
            w_1       <= '0;
            w_2       <= '0;
            w_3       <= '0;
            round_cnt <= 4'd0;
            key_valid <= 1'b0;
        end else if (kld) begin
            w_0       <= key[127:96];
            w_1       <= key[95:64];
            w_2       <= key[63:32];
            w_3       <= key[31:0];
            round_cnt <= 4'd0;
            key_valid <= 1'b1;
        end else if (do_adv) begin
            w_0       <= w0_n;
            w_1       <= w1_n;
            w_2       <= w2_n;
            w_3       <= w3_n;
            round_cnt <= round_n;
        end
    end

    // Final round flag derived from registered state only.
    assign key_last = key_valid & (round_cnt == AES_NR);

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Self-checking bench for aes_key_expand_128 against a FIPS-197 style
// key-expansion model built from GF(2^8) arithmetic.
module tb_aes_key_expand_128;

    typedef logic [31:0] ks_t [44];

    logic         clk;
    logic         rst_n;
    logic         kld;
    logic [127:0] key;
    logic         adv;
    logic [31:0]  w_0;
    logic [31:0]  w_1;
    logic [31:0]  w_2;
    logic [31:0]  w_3;
    logic [3:0]   round_cnt;
    logic         key_valid;
    logic         key_last;

    int n_checks;
    int n_errors;

    logic [7:0]   m_sbox [256];
    logic [127:0] m_key;
    int           m_round;
    logic         m_valid;

    aes_key_expand_128 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kld       (kld),
        .key       (key),
        .adv       (adv),
        .w_0       (w_0),
        .w_1       (w_1),
        .w_2       (w_2),
        .w_3       (w_3),
        .round_cnt (round_cnt),
        .key_valid (key_valid),
        .key_last  (key_last)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model helpers ----------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_def(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (b != 8'h00 && gf_mul(b, 8'(y)) == 8'h01) inv = 8'(y);
        end
        s = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = rotl8(r);
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_m(input int i);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < i; k++) r = xtime(r);
        return r;
    endfunction

    // Textbook key expansion: w[i] = w[i-4] ^ temp, temp transformed every 4th word.
    function automatic ks_t expand(input logic [127:0] k);
        ks_t        w;
        logic [31:0] temp;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {m_sbox[temp[31:24]], m_sbox[temp[23:16]],
                        m_sbox[temp[15:8]], m_sbox[temp[7:0]]};
                temp = temp ^ {rcon_m(i / 4), 24'h000000};
            end
            w[i] = w[i-4] ^ temp;
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model state ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_key   <= '0;
            m_round <= 0;
            m_valid <= 1'b0;
        end else if (kld) begin
            m_key   <= key;
            m_round <= 0;
            m_valid <= 1'b1;
        end else if (adv && m_valid && m_round < 10) begin
            m_round <= m_round + 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        ks_t          ks;
        logic [127:0] exp_w;
        ks = expand(m_key);
        exp_w = m_valid ? {ks[4*m_round], ks[4*m_round+1], ks[4*m_round+2], ks[4*m_round+3]}
                        : 128'h0;
        check("cyc_w", {w_0, w_1, w_2, w_3}, exp_w);
        check("cyc_round_cnt", 128'(round_cnt), 128'(m_round));
        check("cyc_key_valid", 128'(key_valid), 128'(m_valid));
        check("cyc_key_last", 128'(key_last), 128'(m_valid && m_round == 10));
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic k, input logic [127:0] kv, input logic a);
        @(negedge clk);
        kld = k;
        key = kv;
        adv = a;
        @(posedge clk);
        #1;
        kld = 1'b0;
        adv = 1'b0;
    endtask

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] rk;
        logic [127:0] hold;
        n_checks = 0;
        n_errors = 0;
        for (int b = 0; b < 256; b++) m_sbox[b] = sbox_def(8'(b));

        rst_n = 1'b0;
        kld   = 1'b0;
        adv   = 1'b0;
        key   = '0;

        // model pins against hand-known constants
        check("pin_sbox_00", 128'(m_sbox[8'h00]), 128'h63);
        check("pin_sbox_53", 128'(m_sbox[8'h53]), 128'hed);
        check("pin_sbox_ff", 128'(m_sbox[8'hff]), 128'h16);
        check("pin_rcon_9", 128'(rcon_m(9)), 128'h1b);
        check("pin_rcon_10", 128'(rcon_m(10)), 128'h36);

        // reset held with random activity on the inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            kld = 1'($urandom_range(0, 1));
            adv = 1'($urandom_range(0, 1));
            key = {$urandom, $urandom, $urandom, $urandom};
        end
        @(posedge clk);
        #1;
        check("rst_w", {w_0, w_1, w_2, w_3}, 128'h0);
        check("rst_flags", {round_cnt, key_valid, key_last}, 128'h0);
        @(negedge clk);
        kld = 1'b0;
        adv = 1'b0;
        rst_n = 1'b1;

        // adv without a loaded key is ignored
        cyc(1'b0, KEY_B, 1'b1);
        cyc(1'b0, '0, 1'b0);
        check("noload_w", {w_0, w_1, w_2, w_3}, 128'h0);
        check("noload_valid", 128'(key_valid), 128'h0);

        // FIPS-197 A.1 schedule
        cyc(1'b1, KEY_A, 1'b0);
        check("a1_r0", {w_0, w_1, w_2, w_3}, KEY_A);
        check("a1_r0_cnt", 128'(round_cnt), 128'h0);
        cyc(1'b0, '0, 1'b1);
        check("a1_r1", {w_0, w_1, w_2, w_3}, 128'ha0fafe1788542cb123a339392a6c7605);
        check("a1_r1_cnt", 128'(round_cnt), 128'h1);
        cyc(1'b0, '0, 1'b1);
        check("a1_r2", {w_0, w_1, w_2, w_3}, 128'hf2c295f27a96b9435935807a7359f67f);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
        rk = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        check("a1_r10", {w_0, w_1, w_2, w_3}, rk);
        check("a1_r10_cnt", 128'(round_cnt), 128'd10);
        check("a1_r10_last", 128'(key_last), 128'h1);

        // saturation
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        check("sat_w", {w_0, w_1, w_2, w_3}, rk);
        check("sat_last", {round_cnt, key_last}, {4'd10, 1'b1});

        // idle hold
        for (int i = 0; i < 4; i++) cyc(1'b0, KEY_B, 1'b0);
        check("idle_w", {w_0, w_1, w_2, w_3}, rk);

        // reload mid-schedule
        cyc(1'b1, KEY_A, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
        check("mid_r5_cnt", 128'(round_cnt), 128'd5);
        cyc(1'b1, KEY_B, 1'b0);
        check("reload_r0", {w_0, w_1, w_2, w_3}, KEY_B);
        check("reload_cnt", 128'(round_cnt), 128'h0);
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1);
        check("reload_r10", {w_0, w_1, w_2, w_3}, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("reload_last", 128'(key_last), 128'h1);

        // kld and adv together: load wins
        cyc(1'b1, KEY_A, 1'b0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        hold = {$urandom, $urandom, $urandom, $urandom};
        cyc(1'b1, hold, 1'b1);
        check("prio_w", {w_0, w_1, w_2, w_3}, hold);
        check("prio_cnt", 128'(round_cnt), 128'h0);

        // asynchronous reset mid-schedule
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        check("ar_r3_cnt", 128'(round_cnt), 128'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_w", {w_0, w_1, w_2, w_3}, 128'h0);
        check("ar_flags", {round_cnt, key_valid, key_last}, 128'h0);
        #3;
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("ar_adv_ignored", {w_0, w_1, w_2, w_3, round_cnt, key_valid}, 128'h0);

        // randomized traffic, compare process checks every cycle
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            kld = ($urandom_range(0, 15) == 0);
            adv = ($urandom_range(0, 3) != 0);
            key = {$urandom, $urandom, $urandom, $urandom};
            rst_n = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        kld = 1'b0;
        adv = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
